// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch unit: address/request out, ack/data back.
// The fetch unit uses the master side; the memory (or a model of it) uses the slave side.
interface fetch_unit_if #(
  parameter int PC_W = 16,
  parameter int IR_W = 32
);
  logic [PC_W-1:0] im_addr;
  logic            im_req;
  logic            im_ack;
  logic [IR_W-1:0] im_data;

  modport master (
    output im_addr,
    output im_req,
    input  im_ack,
    input  im_data
  );

  modport slave (
    input  im_addr,
    input  im_req,
    output im_ack,
    output im_data
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction register for the SISC core.
// Holds the PC (sequential / absolute / relative branch updates) and runs a
// two-state IDLE/REQ fetch over a req/ack instruction-memory port, with a
// bounded wait for im_ack that ends in a NOOP and a sticky timeout flag.
// Optional feature macro: PC_BOUNDS_EN -- any PC update landing above
// PC_LIMIT reloads RST_VEC and sets the sticky pc_err flag.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              IR_W     = 32,
  parameter logic [PC_W-1:0] RST_VEC  = '0,
  parameter int              TMO      = 15,
  parameter logic [PC_W-1:0] PC_LIMIT = '1
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            ir_load,
  fetch_unit_if.master    im,
  output logic [IR_W-1:0] ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [PC_W-1:0] pc_out,
  output logic            ir_valid,
  output logic            fetch_busy,
  output logic            fetch_tmo,
  output logic            pc_err
);

`ifdef PC_BOUNDS_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_calc;
  logic [PC_W-1:0] tgt;
  logic            pc_oob;
  logic            pc_err_reg;
  logic [IR_W-1:0] ir_reg;
  logic [0:0]      state_reg;
  logic [7:0]      cnt_reg;
  logic [PC_W-1:0] im_addr_reg;
  logic            im_req_reg;
  logic            ir_valid_reg;
  logic            fetch_tmo_reg;
  logic [15:0]     imm;

  assign imm = ir_reg[15:0];

  // Next-PC selection: sequential or branch target, all arithmetic wraps modulo 2^PC_W
  always_comb begin
    tgt     = br_sel ? PC_W'(imm) : pc_reg + PC_W'(signed'(imm));
    pc_calc = pc_sel ? tgt : pc_reg + PC_W'(1);
    pc_oob  = BOUNDS_EN && (pc_calc > PC_LIMIT);
    pc_next = pc_oob ? RST_VEC : pc_calc;
  end

  // PC register: restart beats a write; out-of-range results latch the sticky error
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_reg     <= RST_VEC;
      pc_err_reg <= 1'b0;
    end else if (pc_rst) begin
      pc_reg <= RST_VEC;
    end else if (pc_write) begin
      pc_reg <= pc_next;
      if (pc_oob) begin
        pc_err_reg <= 1'b1;
      end
    end
  end

  // Fetch FSM: latch address on ir_load, wait for ack or give up after TMO cycles
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      im_addr_reg   <= '0;
      im_req_reg    <= 1'b0;
      ir_reg        <= '0;
      ir_valid_reg  <= 1'b0;
      fetch_tmo_reg <= 1'b0;
    end else begin
      ir_valid_reg <= 1'b0;
      if (pc_rst) begin
        // abort any outstanding fetch; a same-edge ack is dropped
        state_reg  <= ST_IDLE;
        im_req_reg <= 1'b0;
        cnt_reg    <= '0;
      end else if (state_reg == ST_IDLE) begin
        if (ir_load) begin
          im_addr_reg <= pc_reg;
          im_req_reg  <= 1'b1;
          cnt_reg     <= '0;
          state_reg   <= ST_REQ;
        end
      end else begin
        if (im.im_ack) begin
          ir_reg       <= im.im_data;
          ir_valid_reg <= 1'b1;
          im_req_reg   <= 1'b0;
          state_reg    <= ST_IDLE;
        end else if (cnt_reg == 8'(TMO - 1)) begin
          // waited TMO cycles: hand the core a NOOP and flag it
          ir_reg        <= '0;
          fetch_tmo_reg <= 1'b1;
          ir_valid_reg  <= 1'b1;
          im_req_reg    <= 1'b0;
          state_reg     <= ST_IDLE;
        end else begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end
    end
  end

  assign im.im_addr = im_addr_reg;
  assign im.im_req  = im_req_reg;
  assign ir         = ir_reg;
  assign opcode     = ir_reg[IR_W-1 -: 4];
  assign mm         = ir_reg[IR_W-5 -: 4];
  assign pc_out     = pc_reg;
  assign ir_valid   = ir_valid_reg;
  assign fetch_busy = (state_reg == ST_REQ);
  assign fetch_tmo  = fetch_tmo_reg;
  assign pc_err     = pc_err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed stimulus, scoreboard queues filled by the
// stimulus tasks and drained by a negedge monitor (im_req rise, ir_valid pulse).
module tb_fetch_unit;

  typedef struct {
    logic [31:0] ir;
    logic        tmo;
  } exp_t;

`ifdef PC_BOUNDS_EN
  localparam logic [15:0] EXP_FFFF = 16'h0000;
  localparam logic [15:0] EXP_WRAP = 16'h0001;
  localparam logic [15:0] BND_A    = 16'h0000;
  localparam logic [15:0] BND_B    = 16'h0001;
  localparam logic        EXP_ERR  = 1'b1;
`else
  localparam logic [15:0] EXP_FFFF = 16'hFFFF;
  localparam logic [15:0] EXP_WRAP = 16'h0000;
  localparam logic [15:0] BND_A    = 16'h0100;
  localparam logic [15:0] BND_B    = 16'h0101;
  localparam logic        EXP_ERR  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        pc_rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_sel = 1'b0;
  logic        br_sel = 1'b0;
  logic        ir_load = 1'b0;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc_out;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fetch_tmo;
  logic        pc_err;

  int tests = 0;
  int fails = 0;

  logic [15:0] addr_q[$];
  exp_t        ir_q[$];
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;

  fetch_unit_if #(.PC_W(16), .IR_W(32)) im_bus ();

  fetch_unit #(.PC_LIMIT(16'h00FF)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .im         (im_bus),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .pc_out     (pc_out),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_tmo  (fetch_tmo),
    .pc_err     (pc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // complete fetch: ack after 'waits' REQ cycles
  task automatic fetch(input logic [15:0] addr, input int waits, input logic [31:0] data,
                       input logic tmo_exp);
    exp_t e;
    e.ir  = data;
    e.tmo = tmo_exp;
    addr_q.push_back(addr);
    ir_q.push_back(e);
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    chk("req_latency", {30'd0, im_bus.im_req, fetch_busy}, 32'd3);
    repeat (waits) step();
    im_bus.im_ack  = 1'b1;
    im_bus.im_data = data;
    step();
    im_bus.im_ack  = 1'b0;
    im_bus.im_data = '0;
    chk("opcode", {28'd0, opcode}, {28'd0, data[31:28]});
    chk("mm", {28'd0, mm}, {28'd0, data[27:24]});
    step();
    chk("ir_valid_drop", {31'd0, ir_valid}, 32'd0);
  endtask

  task automatic pcw(input string name, input logic sel, input logic br, input logic [15:0] exp);
    pc_write = 1'b1;
    pc_sel   = sel;
    br_sel   = br;
    step();
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    chk(name, {16'd0, pc_out}, {16'd0, exp});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_f) begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (im_bus.im_req && !prev_req) begin
        if (addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got im_req at addr %h, expected none", im_bus.im_addr);
        end else begin
          chk("im_addr", {16'd0, im_bus.im_addr}, {16'd0, addr_q.pop_front()});
        end
      end
      if (ir_valid) begin
        chk("ir_valid_pulse", {31'd0, prev_valid}, 32'd0);
        if (ir_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ir_valid: got ir %h, expected no ir_valid", ir);
        end else begin
          exp_t e;
          e = ir_q.pop_front();
          chk("ir", ir, e.ir);
          chk("fetch_tmo", {31'd0, fetch_tmo}, {31'd0, e.tmo});
          $display("[TB] t=%0t fetch ir=%h opcode=%h mm=%h tmo=%0b", $time, ir, opcode, mm, fetch_tmo);
        end
      end
      prev_req   = im_bus.im_req;
      prev_valid = ir_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    im_bus.im_ack  = 1'b0;
    im_bus.im_data = '0;
    #2 rst_f = 1'b0;
    step();
    step();
    chk("rst_pc", {16'd0, pc_out}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_im_req", {31'd0, im_bus.im_req}, 32'd0);
    chk("rst_im_addr", {16'd0, im_bus.im_addr}, 32'd0);
    chk("rst_flags", {28'd0, ir_valid, fetch_busy, fetch_tmo, pc_err}, 32'd0);
    rst_f = 1'b1;
    step();

    // basic fetch with 2 wait cycles
    fetch(16'h0000, 2, 32'h8123_0004, 1'b0);
    chk("fetch_tmo_clear", {31'd0, fetch_tmo}, 32'd0);

    // branch targets
    fetch(16'h0000, 0, 32'h0000_0010, 1'b0);
    pcw("pc_abs_0010", 1'b1, 1'b1, 16'h0010);
    fetch(16'h0010, 1, 32'h1000_FFFE, 1'b0);
    pcw("pc_rel_000E", 1'b1, 1'b0, 16'h000E);
    fetch(16'h000E, 0, 32'h2000_0040, 1'b0);
    pcw("pc_abs_0040", 1'b1, 1'b1, 16'h0040);
    fetch(16'h0040, 3, 32'h3000_FFFF, 1'b0);
    pcw("pc_abs_FFFF", 1'b1, 1'b1, EXP_FFFF);
    pcw("pc_wrap", 1'b0, 1'b0, EXP_WRAP);
    chk("pc_err_wrap", {31'd0, pc_err}, {31'd0, EXP_ERR});

    // fetch timeout: no ack ever
    addr_q.push_back(EXP_WRAP);
    e.ir  = 32'h0;
    e.tmo = 1'b1;
    ir_q.push_back(e);
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    n = 0;
    while (im_bus.im_req && n < 40) begin
      n++;
      step();
    end
    chk("tmo_cycles", n, 32'd15);
    chk("tmo_ir", ir, 32'd0);
    chk("tmo_flag", {31'd0, fetch_tmo}, 32'd1);
    step();

    // get to pc=5
    pc_rst = 1'b1;
    step();
    pc_rst = 1'b0;
    chk("pc_rst", {16'd0, pc_out}, 32'd0);
    for (int i = 1; i <= 5; i++) pcw("pc_inc", 1'b0, 1'b0, 16'(i));

    // pc_write and second ir_load during REQ
    addr_q.push_back(16'h0005);
    e.ir  = 32'h3456_0007;
    e.tmo = 1'b1;
    ir_q.push_back(e);
    ir_load = 1'b1;
    step();
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    ir_load  = 1'b0;
    chk("midreq_pc", {16'd0, pc_out}, 32'h0006);
    chk("midreq_addr", {16'd0, im_bus.im_addr}, 32'h0005);
    im_bus.im_ack  = 1'b1;
    im_bus.im_data = 32'h3456_0007;
    step();
    im_bus.im_ack  = 1'b0;
    im_bus.im_data = '0;
    step();
    step();
    chk("single_fetch", {31'd0, fetch_busy}, 32'd0);

    // pc_rst and im_ack on the same edge
    addr_q.push_back(16'h0006);
    ir_load = 1'b1;
    step();
    ir_load        = 1'b0;
    pc_rst         = 1'b1;
    im_bus.im_ack  = 1'b1;
    im_bus.im_data = 32'hDEAD_BEEF;
    step();
    pc_rst         = 1'b0;
    im_bus.im_ack  = 1'b0;
    im_bus.im_data = '0;
    chk("abort_pc", {16'd0, pc_out}, 32'd0);
    chk("abort_ir", ir, 32'h3456_0007);
    chk("abort_state", {29'd0, ir_valid, fetch_busy, im_bus.im_req}, 32'd0);
    step();
    step();

    // async reset mid-REQ
    addr_q.push_back(16'h0000);
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    step();
    #3 rst_f = 1'b0;
    #1;
    chk("async_req", {30'd0, im_bus.im_req, fetch_busy}, 32'd0);
    chk("async_ir", ir, 32'd0);
    chk("async_flags", {29'd0, ir_valid, fetch_tmo, pc_err}, 32'd0);
    chk("async_pc_addr", {pc_out, im_bus.im_addr}, 32'd0);
    step();
    rst_f = 1'b1;
    step();

    // bounds check around PC 00FF
    fetch(16'h0000, 0, 32'h4000_00FF, 1'b0);
    pcw("pc_abs_00FF", 1'b1, 1'b1, 16'h00FF);
    pcw("pc_bound_a", 1'b0, 1'b0, BND_A);
    chk("pc_err_a", {31'd0, pc_err}, {31'd0, EXP_ERR});
    pcw("pc_bound_b", 1'b0, 1'b0, BND_B);
    chk("pc_err_sticky", {31'd0, pc_err}, {31'd0, EXP_ERR});

    step();
    step();
    chk("addr_q_drained", addr_q.size(), 32'd0);
    chk("ir_q_drained", ir_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
